// File: rtl/ym_bus_sched_if.sv
// ym_bus_sched_if: groups the CPU port-decoder, aux requester and PSG bus
// signals of the ym2149 TurboSound scheduler.
//   slave  : scheduler side (ym_bus_sched)
//   master : environment side (CPU decoder, aux requester, chip pins)
`timescale 1ns/1ps
interface ym_bus_sched_if;
    logic       cpu_addr_wr;
    logic       cpu_data_wr;
    logic       cpu_rd;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       cpu_wait;
    logic       aux_req;
    logic [3:0] aux_reg;
    logic [7:0] aux_data;
    logic       aux_chip;
    logic       aux_ack;
    logic [1:0] psg_bdir;
    logic [1:0] psg_bc;
    logic [7:0] psg_di;
    logic [7:0] psg_do0;
    logic [7:0] psg_do1;
    logic       chip_sel;

    modport slave (
        input  cpu_addr_wr, cpu_data_wr, cpu_rd, cpu_di,
        input  aux_req, aux_reg, aux_data, aux_chip,
        input  psg_do0, psg_do1,
        output cpu_do, cpu_wait, aux_ack, psg_bdir, psg_bc, psg_di, chip_sel
    );

    modport master (
        output cpu_addr_wr, cpu_data_wr, cpu_rd, cpu_di,
        output aux_req, aux_reg, aux_data, aux_chip,
        output psg_do0, psg_do1,
        input  cpu_do, cpu_wait, aux_ack, psg_bdir, psg_bc, psg_di, chip_sel
    );
endinterface

// File: rtl/ym_bus_sched.sv
// ym_bus_sched: drives BDIR/BC/DI of two ym2149 chips, sharing them between
// the Z80 port decoder (absolute priority) and an aux register writer.
// An aux write runs address, data, then re-latches the CPU's last address
// so the CPU never sees the intrusion.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : ym_bus_sched_if.slave (CPU strobes/data, aux req/ack,
//                per-chip BDIR/BC, shared DI, chip DO inputs, chip_sel)
`timescale 1ns/1ps
module ym_bus_sched #(
    parameter bit TS_ENABLE = 1'b1
) (
    input logic           CLK,
    input logic           RESET,
    ym_bus_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_AUX_ADDR, S_AUX_DATA, S_RESTORE, S_DEFER, S_ACK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_chip_sel;
    logic [1:0][7:0] r_shadow;
    logic            r_pending;
    logic [7:0]      r_pend_data;
    logic            r_pend_chip;

    logic       w_bdir, w_bc, w_tgt, w_wait, w_adv;
    logic [7:0] w_di;
    logic       w_shadow_we, w_pend_set, w_pend_clr;

    // FE/FF select a chip instead of reaching the bus
    wire w_ts_sel  = TS_ENABLE && bus.cpu_addr_wr && (bus.cpu_di[7:1] == 7'h7F);
    wire w_cpu_aw  = bus.cpu_addr_wr && !w_ts_sel;
    wire w_cpu_dw  = bus.cpu_data_wr && !bus.cpu_addr_wr;
    // CPU chip's latch currently holds aux_reg, not the CPU's address
    wire w_dirty   = ((r_state == S_AUX_DATA) || (r_state == S_RESTORE)) &&
                     (bus.aux_chip == r_chip_sel);
    wire w_rd_wait = bus.cpu_rd && w_dirty;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_chip_sel  <= 1'b0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            r_pend_data <= 8'h00;
            r_pend_chip <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ts_sel)
                r_chip_sel <= ~bus.cpu_di[0];
            if (w_shadow_we)
                r_shadow[r_chip_sel] <= bus.cpu_di;
            if (w_pend_set) begin
                r_pending   <= 1'b1;
                r_pend_data <= bus.cpu_di;
                r_pend_chip <= r_chip_sel;
            end else if (w_pend_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bdir      = 1'b0;
        w_bc        = 1'b0;
        w_tgt       = r_chip_sel;
        w_di        = 8'h00;
        w_wait      = 1'b0;
        w_adv       = 1'b0;
        w_shadow_we = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;

        if (w_rd_wait) begin
            // stall the read and put the CPU address back first
            w_wait = 1'b1;
            w_bdir = 1'b1;
            w_bc   = 1'b1;
            w_tgt  = bus.aux_chip;
            w_di   = r_shadow[bus.aux_chip];
            if (r_state == S_RESTORE)
                w_state_nxt = r_pending ? S_DEFER : S_ACK;
            else
                w_state_nxt = S_AUX_ADDR;
        end else if (w_cpu_aw) begin
            w_bdir      = 1'b1;
            w_bc        = 1'b1;
            w_di        = bus.cpu_di;
            w_shadow_we = 1'b1;
            // CPU overwrote the aux chip's latch: aux must re-address,
            // and a pending restore is no longer needed
            if (bus.aux_chip == r_chip_sel) begin
                if (r_state == S_AUX_DATA)
                    w_state_nxt = S_AUX_ADDR;
                else if (r_state == S_RESTORE)
                    w_state_nxt = r_pending ? S_DEFER : S_ACK;
            end
        end else if (w_ts_sel) begin
            w_state_nxt = r_state;
        end else if (w_cpu_dw && !w_dirty) begin
            w_bdir = 1'b1;
            w_di   = bus.cpu_di;
        end else if (bus.cpu_rd) begin
            w_bc = 1'b1;
        end else begin
            w_adv      = 1'b1;
            // data write aimed at a dirty latch is deferred past the restore
            w_pend_set = w_cpu_dw && !r_pending;
            case (r_state)
                S_IDLE:     if (bus.aux_req) w_state_nxt = S_AUX_ADDR;
                S_AUX_ADDR: begin
                    w_bdir = 1'b1;
                    w_bc   = 1'b1;
                    w_tgt  = bus.aux_chip;
                    w_di   = {4'h0, bus.aux_reg};
                    w_state_nxt = S_AUX_DATA;
                end
                S_AUX_DATA: begin
                    w_bdir = 1'b1;
                    w_tgt  = bus.aux_chip;
                    w_di   = bus.aux_data;
                    w_state_nxt = S_RESTORE;
                end
                S_RESTORE: begin
                    w_bdir = 1'b1;
                    w_bc   = 1'b1;
                    w_tgt  = bus.aux_chip;
                    w_di   = r_shadow[bus.aux_chip];
                    w_state_nxt = (r_pending || w_pend_set) ? S_DEFER : S_ACK;
                end
                S_DEFER: begin
                    w_bdir     = 1'b1;
                    w_tgt      = r_pend_chip;
                    w_di       = r_pend_data;
                    w_pend_clr = 1'b1;
                    w_state_nxt = S_ACK;
                end
                S_ACK:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_chip
        assign bus.psg_bdir[c] = !RESET && w_bdir && (w_tgt == 1'(c));
        assign bus.psg_bc[c]   = !RESET && w_bc   && (w_tgt == 1'(c));
    end

    // ack only when ACK actually retires, so a CPU stall cannot stretch it
    assign bus.aux_ack  = !RESET && w_adv && (r_state == S_ACK);
    assign bus.psg_di   = RESET ? 8'h00 : w_di;
    assign bus.cpu_wait = !RESET && w_wait;
    assign bus.cpu_do   = !bus.cpu_rd ? 8'hFF : (r_chip_sel ? bus.psg_do1 : bus.psg_do0);
    assign bus.chip_sel = r_chip_sel;
endmodule
